// File: rtl/alu_pin_responder.sv
// ---------------------------------------------------------------------------
// alu_pin_responder
//   User-project-side responder for the dual 4-bit ALU pin protocol.
//   The operand/select bus on io_in[37:18] is synchronised to wb_clk_i and
//   filtered until it has been stable for STABLE_CYCLES cycles. Both ALU
//   results are then computed and presented on the pads with a valid flag.
//
// Ports
//   wb_clk_i       system clock
//   wb_rst_i       asynchronous active-high reset
//   io_in[37:18]   {sel1[1:0], sel0[1:0], B1, A1, B0, A0}; other bits ignored
//   io_out         [0]=valid [8:4]=R0 [13:9]=R1 [16:14]=count [17]=busy,
//                  all other bits 0
//   io_oeb         active-low enables: 0 on [0] and [17:4], 1 elsewhere
// ---------------------------------------------------------------------------
module alu_pin_responder #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 3
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [37:0] io_in,
    output logic [37:0] io_out,
    output logic [37:0] io_oeb
);

    typedef enum logic [1:0] {IDLE, SETTLE, COMPUTE, PRESENT} state_t;

    // Last stability count value before acceptance; the accepting edge is
    // the STABLE_CYCLES-th consecutive unchanged cycle.
    localparam logic [3:0] STAB_LAST = 4'(STABLE_CYCLES - 1);

    state_t             state_reg, state_next;
    logic [19:0]        sync_reg, s_reg, s_d_reg;
    logic [19:0]        cap_reg, cap_next;
    logic [3:0]         stab_reg, stab_next;
    logic [4:0]         r0_reg, r0_next, r1_reg, r1_next;
    logic [4:0]         out0_reg, out0_next, out1_reg, out1_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               valid_reg, valid_next, busy_reg, busy_next;
    logic [9:0]         alu_res;
    logic               unused_pins;

    assign unused_pins = ^io_in[17:0];

    function automatic logic [4:0] alu_op(input logic [3:0] a, input logic [3:0] b,
                                          input logic [1:0] sel);
        logic [4:0] r;
        case (sel)
            2'b00:   r = {1'b0, a} + {1'b0, b};
            2'b01:   r = {1'b0, a} - {1'b0, b};
            2'b10:   r = {1'b0, a & b};
            default: r = {1'b0, a | b};
        endcase
        return r;
    endfunction

    // Channel gi: A at [8gi+3:8gi], B at [8gi+7:8gi+4], sel at [16+2gi+1:16+2gi].
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_alu
            assign alu_res[gi*5 +: 5] = alu_op(cap_reg[gi*8 +: 4],
                                               cap_reg[gi*8 + 4 +: 4],
                                               cap_reg[16 + gi*2 +: 2]);
        end
    endgenerate

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_reg <= IDLE;
            sync_reg  <= '0;
            s_reg     <= '0;
            s_d_reg   <= '0;
            cap_reg   <= '0;
            stab_reg  <= '0;
            r0_reg    <= '0;
            r1_reg    <= '0;
            out0_reg  <= '0;
            out1_reg  <= '0;
            cnt_reg   <= '0;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            sync_reg  <= io_in[37:18];
            s_reg     <= sync_reg;
            s_d_reg   <= s_reg;
            cap_reg   <= cap_next;
            stab_reg  <= stab_next;
            r0_reg    <= r0_next;
            r1_reg    <= r1_next;
            out0_reg  <= out0_next;
            out1_reg  <= out1_next;
            cnt_reg   <= cnt_next;
            valid_reg <= valid_next;
            busy_reg  <= busy_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cap_next   = cap_reg;
        stab_next  = stab_reg;
        r0_next    = r0_reg;
        r1_next    = r1_reg;
        out0_next  = out0_reg;
        out1_next  = out1_reg;
        cnt_next   = cnt_reg;
        valid_next = valid_reg;
        busy_next  = busy_reg;
        case (state_reg)
            IDLE: begin
                // Comparing against the captured operands (not the delayed
                // copy) means a change arriving during COMPUTE/PRESENT is
                // still picked up here, and repeats of the same value are not.
                if (s_reg != cap_reg) begin
                    state_next = SETTLE;
                    stab_next  = '0;
                    busy_next  = 1'b1;
                    valid_next = 1'b0;
                end
            end
            SETTLE: begin
                if (s_reg != s_d_reg) begin
                    stab_next = '0;
                end else if (stab_reg == STAB_LAST) begin
                    cap_next   = s_reg;
                    stab_next  = '0;
                    state_next = COMPUTE;
                end else begin
                    stab_next = stab_reg + 4'd1;
                end
            end
            COMPUTE: begin
                r0_next    = alu_res[4:0];
                r1_next    = alu_res[9:5];
                state_next = PRESENT;
            end
            PRESENT: begin
                out0_next  = r0_reg;
                out1_next  = r1_reg;
                cnt_next   = cnt_reg + 1'b1;
                valid_next = 1'b1;
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign io_out = {20'h0, busy_reg, cnt_reg, out1_reg, out0_reg, 3'b000, valid_reg};
    assign io_oeb = {20'hFFFFF, 14'h0000, 3'b111, 1'b0};

endmodule
